// File: rtl/uart_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : uart_arb_pkg
// Description : Shared types and helpers for the UART TX push arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_arb_pkg;

    localparam int PAYLOAD_W = 8;
    localparam int MAX_N     = 8;
    localparam int MAX_IDX_W = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [MAX_IDX_W-1:0] idx;
        logic                 found;
    } rr_pick_t;

    // First set bit of valid at or after ptr, wrapping at n (n <= MAX_N).
    function automatic rr_pick_t rr_pick(
        input logic [MAX_N-1:0]     valid,
        input logic [MAX_IDX_W-1:0] ptr,
        input int unsigned          n
    );
        rr_pick_t    res;
        int unsigned cand;
        res.idx   = '0;
        res.found = 1'b0;
        for (int unsigned k = 0; k < MAX_N; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= n) begin
                cand = cand - n;
            end
            if (k < n && !res.found && valid[cand[MAX_IDX_W-1:0]]) begin
                res.idx   = cand[MAX_IDX_W-1:0];
                res.found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : uart_rr_picker
// Description : Combinational rotating priority encoder starting at ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rr_picker
    import uart_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    logic [MAX_N-1:0]     valid_ext;
    logic [MAX_IDX_W-1:0] ptr_ext;
    rr_pick_t             pick;
    logic                 unused_pick_bits;

    always_comb begin
        valid_ext          = '0;
        valid_ext[N-1:0]   = valid;
        ptr_ext            = '0;
        ptr_ext[IDX_W-1:0] = ptr;
        pick               = rr_pick(valid_ext, ptr_ext, N);
    end

    assign idx              = pick.idx[IDX_W-1:0];
    assign found            = pick.found;
    assign unused_pick_bits = ^pick.idx;

endmodule
`default_nettype wire

// File: rtl/uart_tx_push_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_push_arbiter
// Description : Message-locked round-robin arbiter for the UART TX FIFO push
//               port. Define UART_ARB_TIMEOUT_EN to release a stalled owner.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_push_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N              = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                   io_mainClk,
    input  logic                   resetCtrl_systemReset,
    input  logic                   io_flush,
    input  logic [N-1:0]           io_req_valid,
    output logic [N-1:0]           io_req_ready,
    input  logic [PAYLOAD_W*N-1:0] io_req_payload,
    input  logic [N-1:0]           io_req_last,
    output logic                   io_push_valid,
    input  logic                   io_push_ready,
    output logic [PAYLOAD_W-1:0]   io_push_payload,
    output logic                   io_fifo_flush,
    output logic [N-1:0]           io_grant,
    output logic                   io_locked,
    output logic                   io_timeout
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    arb_state_t           state, state_nxt;
    logic [IDX_W-1:0]     rr_ptr, rr_ptr_nxt;
    logic [IDX_W-1:0]     owner, owner_nxt;
    logic [IDX_W-1:0]     pick_idx, sel;
    logic                 pick_found, have, fire, sel_valid, sel_last;
    logic [N-1:0]         sel_onehot;
    logic                 timeout_hit;
    logic [PAYLOAD_W-1:0] req_byte [N];

    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] x);
        return (32'(x) == N - 1) ? '0 : x + 1'b1;
    endfunction

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign req_byte[i] = io_req_payload[i*PAYLOAD_W +: PAYLOAD_W];
    end

    uart_rr_picker #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_picker (
        .valid (io_req_valid),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // While locked the mux is pinned to the owner, valid or not.
    always_comb begin
        have            = (state == LOCKED) || pick_found;
        sel             = (state == LOCKED) ? owner : pick_idx;
        sel_onehot      = have ? (N'(1) << sel) : '0;
        sel_valid       = io_req_valid[sel];
        sel_last        = io_req_last[sel];
        io_grant        = sel_onehot;
        io_push_valid   = !io_flush && have && sel_valid;
        io_push_payload = req_byte[sel];
        io_req_ready    = io_flush ? '0 : (sel_onehot & {N{io_push_ready}});
        fire            = io_push_valid && io_push_ready;
    end

    assign io_locked     = (state == LOCKED);
    assign io_fifo_flush = io_flush;

    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        owner_nxt  = owner;
        if (io_flush) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = '0;
        end else if (timeout_hit) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = rr_next(owner);
        end else if (fire) begin
            if (sel_last) begin
                state_nxt  = IDLE;
                rr_ptr_nxt = rr_next(sel);
            end else begin
                state_nxt = LOCKED;
                owner_nxt = sel;
            end
        end
    end

    always_ff @(posedge io_mainClk or posedge resetCtrl_systemReset) begin
        if (resetCtrl_systemReset) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_ptr_nxt;
            owner  <= owner_nxt;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] idle_cnt;
    logic             timeout_pulse;

    assign timeout_hit = (state == LOCKED) && !io_req_valid[owner] &&
                         (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge io_mainClk or posedge resetCtrl_systemReset) begin
        if (resetCtrl_systemReset) begin
            idle_cnt      <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= timeout_hit && !io_flush;
            if (io_flush || timeout_hit || state != LOCKED || io_req_valid[owner]) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

    assign io_timeout = timeout_pulse;
`else
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign io_timeout         = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_push_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_push_arbiter
// Description : Directed + random bench for uart_tx_push_arbiter against a
//               message-level reference model. Honours UART_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_push_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;
`ifdef UART_ARB_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           flush = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_last = '0;
    logic [8*N-1:0] req_payload = '0;
    logic           push_ready = 1'b1;

    logic [N-1:0]   io_req_ready;
    logic [N-1:0]   io_grant;
    logic           io_push_valid, io_locked, io_timeout, io_fifo_flush;
    logic [7:0]     io_push_payload;

    uart_tx_push_arbiter #(
        .N              (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .io_mainClk            (clk),
        .resetCtrl_systemReset (rst),
        .io_flush              (flush),
        .io_req_valid          (req_valid),
        .io_req_ready          (io_req_ready),
        .io_req_payload        (req_payload),
        .io_req_last           (req_last),
        .io_push_valid         (io_push_valid),
        .io_push_ready         (push_ready),
        .io_push_payload       (io_push_payload),
        .io_fifo_flush         (io_fifo_flush),
        .io_grant              (io_grant),
        .io_locked             (io_locked),
        .io_timeout            (io_timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Message-level model: who owns the port, where the round-robin starts.
    bit m_locked;
    int m_owner;
    int m_ptr;
    int m_cnt;
    bit m_pulse;
    int fired_idx;

    int         log_idx[$];
    logic [7:0] log_byte[$];
    logic [N-1:0] pending;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_owner  = 0;
        m_ptr    = 0;
        m_cnt    = 0;
        m_pulse  = 1'b0;
    endtask

    task automatic set_req(input int i, input bit v, input logic [7:0] b, input bit l);
        req_valid[i]          = v;
        req_payload[i*8 +: 8] = b;
        req_last[i]           = l;
    endtask

    task automatic clear_log();
        log_idx.delete();
        log_byte.delete();
    endtask

    // Called at a negedge with inputs already driven; checks, then advances one cycle.
    task automatic step(input string tag);
        int           sel;
        bit           have, exp_pv, fire;
        logic [N-1:0] exp_ready, obs_ready, exp_grant;
        #1;
        have = 1'b0;
        sel  = 0;
        if (m_locked) begin
            have = 1'b1;
            sel  = m_owner;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!have && req_valid[(m_ptr + k) % N]) begin
                    have = 1'b1;
                    sel  = (m_ptr + k) % N;
                end
            end
        end
        exp_grant = have ? N'(1 << sel) : '0;
        exp_pv    = !flush && have && req_valid[sel];
        exp_ready = exp_pv ? (N'(push_ready) << sel) : '0;
        obs_ready = io_req_ready;
        if (have && !exp_pv && !flush) obs_ready[sel] = 1'b0;

        chk({tag, ".grant"},      32'(io_grant),      32'(exp_grant));
        chk({tag, ".push_valid"}, 32'(io_push_valid), 32'(exp_pv));
        chk({tag, ".ready"},      32'(obs_ready),     32'(exp_ready));
        chk({tag, ".locked"},     32'(io_locked),     32'(m_locked));
        chk({tag, ".timeout"},    32'(io_timeout),    32'(m_pulse));
        chk({tag, ".fifo_flush"}, 32'(io_fifo_flush), 32'(flush));
        if (exp_pv) chk({tag, ".payload"}, 32'(io_push_payload), 32'(req_payload[sel*8 +: 8]));

        if (io_push_valid === 1'b1 && push_ready) begin
            for (int i = 0; i < N; i++) if (io_grant[i] === 1'b1) log_idx.push_back(i);
            log_byte.push_back(io_push_payload);
        end

        fire      = exp_pv && push_ready;
        fired_idx = fire ? sel : -1;

        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (flush) begin
            m_locked = 1'b0;
            m_ptr    = 0;
            m_cnt    = 0;
            m_pulse  = 1'b0;
        end else if (TIMEOUT_ON && m_locked && !req_valid[m_owner] && m_cnt == TO - 1) begin
            m_locked = 1'b0;
            m_ptr    = (m_owner + 1) % N;
            m_cnt    = 0;
            m_pulse  = 1'b1;
        end else begin
            m_pulse = 1'b0;
            if (fire) begin
                m_cnt = 0;
                if (req_last[sel]) begin
                    m_locked = 1'b0;
                    m_ptr    = (sel + 1) % N;
                end else begin
                    m_locked = 1'b1;
                    m_owner  = sel;
                end
            end else if (m_locked && !req_valid[m_owner]) begin
                m_cnt++;
            end else begin
                m_cnt = 0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        @(negedge clk);

        // Reset state
        step("reset0");
        step("reset1");
        rst = 1'b0;
        step("idle");

        // Fairness: everyone valid, single-byte messages
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 8'(8'h50 + i), 1'b1);
        clear_log();
        for (int c = 0; c < 8; c++) step("fair");
        chk("fair.count", 32'(log_idx.size()), 32'd8);
        for (int c = 0; c < 8 && c < log_idx.size(); c++) chk("fair.order", 32'(log_idx[c]), 32'(c % N));

        // Message lock: move pointer to req1 first
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'h00, 1'b0);
        set_req(0, 1'b1, 8'h10, 1'b1);
        step("lock.pre");
        set_req(2, 1'b1, 8'h20, 1'b1);
        set_req(1, 1'b1, 8'hA1, 1'b0);
        clear_log();
        step("lock.a1");
        set_req(1, 1'b1, 8'hA2, 1'b0);
        step("lock.a2");
        set_req(1, 1'b1, 8'hA3, 1'b1);
        step("lock.a3");
        set_req(1, 1'b0, 8'h00, 1'b0);
        step("lock.next");
        chk("lock.count", 32'(log_idx.size()), 32'd4);
        if (log_idx.size() == 4) begin
            chk("lock.i0", 32'(log_idx[0]), 32'd1);
            chk("lock.i2", 32'(log_idx[2]), 32'd1);
            chk("lock.i3", 32'(log_idx[3]), 32'd2);
            chk("lock.b0", 32'(log_byte[0]), 32'hA1);
            chk("lock.b1", 32'(log_byte[1]), 32'hA2);
            chk("lock.b2", 32'(log_byte[2]), 32'hA3);
        end

        // Backpressure mid-message by req3
        set_req(2, 1'b0, 8'h00, 1'b0);
        set_req(3, 1'b1, 8'hB1, 1'b0);
        clear_log();
        step("bp.b1");
        set_req(3, 1'b1, 8'hB2, 1'b0);
        push_ready = 1'b0;
        for (int c = 0; c < 5; c++) step("bp.stall");
        chk("bp.nofire", 32'(log_idx.size()), 32'd1);
        push_ready = 1'b1;
        step("bp.b2");
        set_req(3, 1'b1, 8'hB3, 1'b1);
        step("bp.b3");
        chk("bp.count", 32'(log_byte.size()), 32'd3);
        if (log_byte.size() == 3) begin
            chk("bp.b1v", 32'(log_byte[0]), 32'hB1);
            chk("bp.b2v", 32'(log_byte[1]), 32'hB2);
            chk("bp.b3v", 32'(log_byte[2]), 32'hB3);
        end

        // Flush while req3 holds the lock
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'h00, 1'b0);
        set_req(3, 1'b1, 8'hC1, 1'b0);
        step("fl.lock");
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 8'(8'h40 + i), 1'b1);
        flush = 1'b1;
        step("fl.pulse");
        flush = 1'b0;
        clear_log();
        step("fl.after");
        chk("fl.winner", 32'(log_idx.size() > 0 ? log_idx[0] : -1), 32'd0);

        // Owner stall by req2
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'h00, 1'b0);
        set_req(2, 1'b1, 8'hD1, 1'b0);
        step("to.lock");
        set_req(2, 1'b0, 8'h00, 1'b0);
        set_req(0, 1'b1, 8'h60, 1'b1);
        set_req(1, 1'b1, 8'h61, 1'b1);
        set_req(3, 1'b1, 8'h63, 1'b1);
`ifdef UART_ARB_TIMEOUT_EN
        for (int c = 0; c < TO; c++) step("to.wait");
        #1;
        chk("to.pulse", 32'(io_timeout), 32'd1);
        chk("to.grant", 32'(io_grant), 32'(4'b1000));
        step("to.release");
`else
        for (int c = 0; c < 1000; c++) step("hold.wait");
        #1;
        chk("hold.locked", 32'(io_locked), 32'd1);
        chk("hold.grant", 32'(io_grant), 32'(4'b0100));
        set_req(2, 1'b1, 8'hD2, 1'b1);
        step("hold.release");
        set_req(2, 1'b0, 8'h00, 1'b0);
`endif

        // Reset in the middle of a message
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'h00, 1'b0);
        set_req(1, 1'b1, 8'hE1, 1'b0);
        step("rst.lock");
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 8'(8'h70 + i), 1'b1);
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst.unlock", 32'(io_locked), 32'd0);
        step("rst.hold");
        rst = 1'b0;
        step("rst.after");

        // Random traffic honouring the hold-until-ready rule
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'h00, 1'b0);
        pending = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pending[i]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        set_req(i, 1'b1, 8'($urandom), ($urandom_range(0, 1) == 1));
                        pending[i] = 1'b1;
                    end else begin
                        set_req(i, 1'b0, 8'h00, 1'b0);
                    end
                end
            end
            push_ready = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 39) == 0);
            step("rand");
            if (fired_idx >= 0) pending[fired_idx] = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_push_arbiter.md
Name: uart_tx_push_arbiter

Overview:
Round-robin arbiter that shares the single push port of the UART TX byte FIFO among N requesters, such as the APB register path, a DMA engine and a debug console.
Messages are framed by a last flag. Once a requester wins, it owns the port until it pushes its last byte, so messages are never interleaved in the FIFO.
Sits between the requesters and the TX FIFO push interface in the io_mainClk domain.

Parameters:
N, 4, number of requesters (2..8)
TIMEOUT_CYCLES, 256, idle-owner release threshold (used only with UART_ARB_TIMEOUT_EN)

Ports:
io_mainClk  input  1  clock
resetCtrl_systemReset  input  1  asynchronous active-high reset
io_flush  input  1  synchronous flush; also forwarded to the FIFO
io_req_valid  input  N  per-requester byte valid
io_req_ready  output  N  per-requester byte accepted
io_req_payload  input  8*N  requester i byte at [8i+7:8i]
io_req_last  input  N  byte is the final byte of the message
io_push_valid  output  1  to FIFO io_push_valid
io_push_ready  input  1  from FIFO io_push_ready
io_push_payload  output  8  to FIFO io_push_payload
io_fifo_flush  output  1  equals io_flush (combinational)
io_grant  output  N  one-hot current selection; all-zero if none
io_locked  output  1  a message is in progress
io_timeout  output  1  one-cycle pulse on forced release (feature only)

Behaviour:
- Clock is io_mainClk. Reset is resetCtrl_systemReset, asynchronous, active-high.
- State reset values: state=IDLE, rr_ptr=0, owner=0, timeout counter=0.
- Output reset values: io_locked=0, io_timeout=0. io_grant and io_push_valid are 0 unless some io_req_valid is high.
- Zero-latency combinational path. fire = io_push_valid && io_push_ready.
- The push path is valid, ready and payload only; io_req_last is not forwarded to the FIFO.
- IDLE state:
  - sel = first i with io_req_valid[i], searching rr_ptr, rr_ptr+1, ... modulo N.
  - io_grant = onehot(sel); io_push_valid = io_req_valid[sel]; io_push_payload = the sel byte.
  - io_req_ready[sel] = io_push_ready; all other ready bits are 0.
  - fire && !last -> LOCKED, owner <= sel.
  - fire && last -> stay IDLE, rr_ptr <= (sel+1) mod N.
  - No fire -> no state change. The winner is recomputed every cycle, so a requester is not guaranteed the grant until it fires.
- LOCKED state:
  - io_grant = onehot(owner); the mux is forced to owner; io_locked = 1.
  - If the owner drops valid, io_push_valid = 0 and the lock is held. Other requesters stay stalled with ready = 0.
  - Owner fire && last -> IDLE, rr_ptr <= (owner+1) mod N.
- Requesters must hold valid, payload and last stable until ready. Valid must not depend on ready.
- FIFO full (io_push_ready=0): no fire; grant and lock are unchanged.
- io_flush=1 has priority over all events in that cycle:
  - io_push_valid = 0 and all io_req_ready = 0.
  - Next cycle: state=IDLE, rr_ptr=0, timeout counter=0.
- rr_ptr is $clog2(N) bits; (x+1) mod N wraps at N-1 even when N is not a power of two.
- Reset asserted mid-message: the lock is dropped immediately; bytes already pushed remain the FIFO's responsibility.

Optional Feature:
Macro UART_ARB_TIMEOUT_EN.
- Defined:
  - The counter increments each LOCKED cycle in which the owner's valid is 0, and clears on any owner valid cycle.
  - When the counter reaches TIMEOUT_CYCLES-1 while still idle: next cycle state=IDLE, rr_ptr=(owner+1) mod N, counter=0, io_timeout pulses for 1 cycle.
  - io_flush overrides the timeout.
- Undefined: no counter is built, io_timeout is tied to 0, and the lock is held indefinitely.

Decomposition:
- Shared package uart_arb_pkg:
  - state encoding typedef (IDLE=1'b0, LOCKED=1'b1);
  - localparam for the payload width (8);
  - a function rr_pick(valid, ptr) returning the index and a found flag.
- One natural sub-module: uart_rr_picker, the combinational rotating priority encoder (N, valid, ptr -> index, found).
- The top level holds the FSM, the mux and the timeout logic.

Test Plan:
- Fairness: N=4, all valid with last=1 every byte, ready=1 -> grant order 0,1,2,3,0; 8 bytes pushed in 8 cycles.
- Message lock: req1 sends 3 bytes 0xA1,0xA2,0xA3 (last on the 3rd) while req0 and req2 are valid -> FIFO receives A1,A2,A3 contiguously, io_locked=1 for those cycles; req2 is granted next.
- Backpressure: io_push_ready=0 for 5 cycles mid-message -> no fire, payload held, grant unchanged; the message resumes intact.
- Flush: LOCKED by req3 and pulse io_flush -> io_fifo_flush=1 that cycle, io_push_valid=0; next cycle state IDLE with rr_ptr=0, and req0 wins when all are valid.
- Owner stall with UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: req2 sends 1 byte with last=0 then drops valid -> io_timeout pulses after 16 idle cycles, then req3 is granted. Without the macro the lock holds for 1000 cycles.
- Reset mid-message: assert reset during the lock -> io_locked=0 immediately, and rr_ptr=0 after release.
